// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the RV32I multicycle control unit.
// Holds the state enum, opcode values, ALU codes and datapath select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECR,
    EXECI,
    ALUWB,
    BEQ,
    JAL,
    TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_dec(input logic [6:0] op);
    unique case (1'b1)
      op == OP_SW:  return IMM_S;
      op == OP_BEQ: return IMM_B;
      op == OP_JAL: return IMM_J;
      default:      return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Control/datapath bundle between the multicycle controller and datapath.
// master = controller side, slave = datapath/memory side.
interface riscv_mc_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write,
    output pc_write, reg_write, result_src,
    output alu_src_a, alu_src_b, imm_src,
    output alu_control, retire, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write,
    input  pc_write, reg_write, result_src,
    input  alu_src_a, alu_src_b, imm_src,
    input  alu_control, retire, illegal
  );
endinterface

// File: rtl/riscv_mc_ctrl_alu_dec.sv
// ALU decoder: ALUOp plus funct fields to ALU control code.
module mc_alu_dec
  import riscv_mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        // op5 separates R-type sub from addi, whose imm[10] aliases funct7b5
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = 3'bxxx;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle control FSM for RV32I lw/sw/R/I/beq/jal on a unified-memory datapath.
module riscv_mc_ctrl
  import riscv_mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic clk,
  input logic reset,
  riscv_mc_ctrl_if.master bus
);

  state_t     state, next;
  logic [1:0] alu_op;
  logic [1:0] result_src, src_a, src_b;
  logic       mem_req, mem_write, adr_src;
  logic       ir_write, pc_write, reg_write;
  logic       retire, illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_B;
    alu_op     = ALUOP_ADD;
    unique case (state)
      FETCH: begin
        mem_req    = 1'b1;
        src_b      = SRCB_4;
        result_src = RES_ALURES;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
        if (bus.mem_ready) next = DECODE;
      end
      DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        unique case (1'b1)
          bus.op == OP_LW:  next = MEMADR;
          bus.op == OP_SW:  next = MEMADR;
          bus.op == OP_R:   next = EXECR;
          bus.op == OP_I:   next = EXECI;
          bus.op == OP_BEQ: next = BEQ;
          bus.op == OP_JAL: next = JAL;
          default: next = HALT_ON_ILLEGAL ? TRAP : FETCH;
        endcase
      end
      MEMADR: begin
        src_a = SRCA_A;
        src_b = SRCB_IMM;
        next  = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ready) next = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        retire    = bus.mem_ready;
        if (bus.mem_ready) next = FETCH;
      end
      EXECR: begin
        src_a  = SRCA_A;
        alu_op = ALUOP_FN;
        next   = ALUWB;
      end
      EXECI: begin
        src_a  = SRCA_A;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_FN;
        next   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        next      = FETCH;
      end
      BEQ: begin
        src_a    = SRCA_A;
        alu_op   = ALUOP_SUB;
        pc_write = bus.zero;
        retire   = 1'b1;
        next     = FETCH;
      end
      JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_4;
        pc_write = 1'b1;
        next     = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
        next    = TRAP;
      end
      default: next = FETCH;
    endcase
    // async reset lands in FETCH, so its memory strobe must be masked too
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  mc_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.alu_control)
  );

  assign bus.imm_src    = imm_dec(bus.op);
  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_write;
  assign bus.adr_src    = adr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.retire     = retire;
  assign bus.illegal    = illegal;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: per-cycle expected control words vs outputs.
module tb_riscv_mc_ctrl;

  typedef struct {
    logic [18:0] e;
    string       n;
  } exp_t;

  logic  clk;
  logic  reset;
  exp_t  q[$];
  int    n_chk;
  int    n_fail;
  logic [1:0]  cur_imm;
  logic [18:0] got;

  riscv_mc_ctrl_if bus ();

  riscv_mc_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got 0 required finish");
    $fatal(1);
  end

  assign got = {bus.mem_req, bus.mem_write, bus.adr_src,
                bus.ir_write, bus.pc_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b,
                bus.imm_src, bus.alu_control,
                bus.retire, bus.illegal};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      n_chk++;
      if (got !== x.e) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", x.n, got, x.e);
      end
    end
  end

  // word: req wr adr irw pcw rw | rs a b imm | alu | ret ill
  function automatic logic [18:0] w(
    input logic req, input logic wr, input logic adr,
    input logic irw, input logic pcw, input logic rw,
    input logic [1:0] rs, input logic [1:0] a,
    input logic [1:0] b, input logic [2:0] al,
    input logic ret, input logic ill);
    return {req, wr, adr, irw, pcw, rw, rs, a, b,
            cur_imm, al, ret, ill};
  endfunction

  function automatic logic [18:0] e_rst();
    return w(0,0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_fetch(input logic r);
    return w(1,0,0,r,r,0,2'b10,2'b00,2'b10,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_dec();
    return w(0,0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_madr();
    return w(0,0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_mrd();
    return w(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_mwb();
    return w(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,1,0);
  endfunction
  function automatic logic [18:0] e_mwr(input logic r);
    return w(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,r,0);
  endfunction
  function automatic logic [18:0] e_exr(input logic [2:0] al);
    return w(0,0,0,0,0,0,2'b00,2'b10,2'b00,al,0,0);
  endfunction
  function automatic logic [18:0] e_exi(input logic [2:0] al);
    return w(0,0,0,0,0,0,2'b00,2'b10,2'b01,al,0,0);
  endfunction
  function automatic logic [18:0] e_awb();
    return w(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,1,0);
  endfunction
  function automatic logic [18:0] e_beq(input logic z);
    return w(0,0,0,0,z,0,2'b00,2'b10,2'b00,3'b001,1,0);
  endfunction
  function automatic logic [18:0] e_jal();
    return w(0,0,0,0,1,0,2'b00,2'b01,2'b10,3'b000,0,0);
  endfunction
  function automatic logic [18:0] e_trap();
    return w(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1);
  endfunction

  task automatic ins(input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic [1:0] imm);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    cur_imm      = imm;
  endtask

  task automatic step(input logic [18:0] e, input string n,
                      input logic rdy, input logic z);
    exp_t x;
    bus.mem_ready = rdy;
    bus.zero      = z;
    x.e = e;
    x.n = n;
    q.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic r_type(input logic [2:0] f3, input logic f7,
                        input logic [2:0] al, input string n);
    ins(7'b0110011, f3, f7, 2'b00);
    step(e_fetch(1), {n, "_fetch"}, 1, 1);
    step(e_dec(), {n, "_dec"}, 1, 1);
    step(e_exr(al), {n, "_exec"}, 1, 1);
    step(e_awb(), {n, "_wb"}, 1, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    ins(7'b0000011, 3'b010, 1'b0, 2'b00);
    #1;
    step(e_rst(), "reset_hold", 1, 0);
    reset = 1'b0;

    step(e_fetch(1), "lw_fetch", 1, 0);
    step(e_dec(), "lw_dec", 0, 0);
    step(e_madr(), "lw_madr", 0, 0);
    step(e_mrd(), "lw_mrd", 1, 0);
    step(e_mwb(), "lw_wb", 0, 0);

    r_type(3'b000, 1'b1, 3'b001, "r_sub");
    r_type(3'b000, 1'b0, 3'b000, "r_add");
    r_type(3'b110, 1'b0, 3'b011, "r_or");
    r_type(3'b111, 1'b0, 3'b010, "r_and");
    r_type(3'b010, 1'b0, 3'b101, "r_slt");

    ins(7'b0010011, 3'b000, 1'b1, 2'b00);
    step(e_fetch(1), "addi_fetch", 1, 0);
    step(e_dec(), "addi_dec", 1, 0);
    step(e_exi(3'b000), "addi_exec", 1, 0);
    step(e_awb(), "addi_wb", 1, 0);

    ins(7'b1100011, 3'b000, 1'b0, 2'b10);
    step(e_fetch(1), "beq1_fetch", 1, 0);
    step(e_dec(), "beq1_dec", 1, 0);
    step(e_beq(1), "beq1_br", 1, 1);
    step(e_fetch(1), "beq0_fetch", 1, 1);
    step(e_dec(), "beq0_dec", 1, 1);
    step(e_beq(0), "beq0_br", 1, 0);

    ins(7'b0010011, 3'b110, 1'b0, 2'b00);
    step(e_fetch(0), "stall_f1", 0, 0);
    step(e_fetch(0), "stall_f2", 0, 0);
    step(e_fetch(0), "stall_f3", 0, 0);
    step(e_fetch(1), "stall_f4", 1, 0);
    step(e_dec(), "ori_dec", 0, 0);
    step(e_exi(3'b011), "ori_exec", 0, 0);
    step(e_awb(), "ori_wb", 0, 0);

    ins(7'b0100011, 3'b010, 1'b0, 2'b01);
    step(e_fetch(1), "sw_fetch", 1, 0);
    step(e_dec(), "sw_dec", 1, 0);
    step(e_madr(), "sw_madr", 1, 0);
    step(e_mwr(0), "sw_wr1", 0, 0);
    step(e_mwr(0), "sw_wr2", 0, 0);
    step(e_mwr(1), "sw_wr3", 1, 0);

    ins(7'b1101111, 3'b000, 1'b0, 2'b11);
    step(e_fetch(1), "jal_fetch", 1, 0);
    step(e_dec(), "jal_dec", 1, 0);
    step(e_jal(), "jal_jump", 1, 0);
    step(e_awb(), "jal_wb", 1, 0);

    ins(7'b0000011, 3'b010, 1'b0, 2'b00);
    step(e_fetch(1), "rlw_fetch", 1, 0);
    step(e_dec(), "rlw_dec", 1, 0);
    step(e_madr(), "rlw_madr", 1, 0);
    step(e_mrd(), "rlw_mrd", 0, 0);
    reset = 1'b1;
    step(e_rst(), "rlw_reset", 1, 0);
    reset = 1'b0;

    ins(7'h7F, 3'b000, 1'b0, 2'b00);
    step(e_fetch(1), "ill_fetch", 1, 0);
    step(e_dec(), "ill_dec", 1, 0);
    step(e_trap(), "ill_trap1", 1, 1);
    step(e_trap(), "ill_trap2", 0, 1);
    step(e_trap(), "ill_trap3", 1, 0);
    reset = 1'b1;
    step(e_rst(), "ill_reset", 1, 0);
    reset = 1'b0;
    step(e_fetch(1), "post_fetch", 1, 0);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
